// File: rtl/conv_enc_param.sv
// Rate-1/2 feed-forward convolutional encoder with run-time puncturing (1/2, 2/3, 3/4),
// optional zero-tail termination and valid/ready handshakes on the serial input and output.
module conv_enc_param #(
    parameter int           K       = 7,
    parameter logic [K-1:0] G0      = 7'o171,
    parameter logic [K-1:0] G1      = 7'o133,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] punct_mode,
    input  logic       din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       done
);

    localparam int             TW       = $clog2(K);
    localparam logic [TW-1:0]  TAIL_LEN = TW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [K-2:0]    sr_r;
    logic [1:0]      phase_r;
    logic [1:0]      mode_r;
    logic [1:0]      pend_r;
    logic [1:0]      cnt_r;
    logic [TW-1:0]   tail_cnt_r;
    logic            last_seen_r;
    logic            done_r;

    logic            slot_s;
    logic            consume_s;
    logic            din_ready_s;
    logic            accept_s;
    logic            tail_inj_s;
    logic            enc_s;
    logic            enc_bit_s;
    logic            a_s;
    logic            b_s;
    logic            keep_a_s;
    logic            keep_b_s;
    logic [1:0]      phase_next_s;
    logic            final_s;
    logic            start_acc_s;

    function automatic logic parity_f(input logic [K-1:0] v);
        return ^v;
    endfunction

    // Handshake qualifiers, encoder core and puncture selection.
    always_comb begin
        slot_s      = (cnt_r == 2'd0) | ((cnt_r == 2'd1) & dout_ready);
        consume_s   = (cnt_r != 2'd0) & dout_ready;
        din_ready_s = (state_r == S_ENC) & ~last_seen_r & slot_s;
        accept_s    = din_ready_s & din_valid;
        tail_inj_s  = (state_r == S_TAIL) & (tail_cnt_r != TAIL_LEN) & slot_s;
        enc_s       = accept_s | tail_inj_s;
        start_acc_s = (state_r == S_IDLE) & start;
        if (accept_s) begin
            enc_bit_s = din;
        end else begin
            enc_bit_s = 1'b0;
        end
        a_s = parity_f({enc_bit_s, sr_r} & G0);
        b_s = parity_f({enc_bit_s, sr_r} & G1);
        keep_a_s     = 1'b1;
        keep_b_s     = 1'b1;
        phase_next_s = 2'd0;
        case (mode_r)
            2'd1: begin
                keep_b_s     = (phase_r == 2'd0);
                phase_next_s = (phase_r == 2'd1) ? 2'd0 : (phase_r + 2'd1);
            end
            2'd2: begin
                keep_a_s     = (phase_r != 2'd2);
                keep_b_s     = (phase_r != 2'd1);
                phase_next_s = (phase_r == 2'd2) ? 2'd0 : (phase_r + 2'd1);
            end
            default: begin
                keep_a_s     = 1'b1;
                keep_b_s     = 1'b1;
                phase_next_s = 2'd0;
            end
        endcase
        // The frame ends when nothing remains to encode and the last pending bit leaves.
        final_s = (((state_r == S_ENC) & last_seen_r) |
                   ((state_r == S_TAIL) & (tail_cnt_r == TAIL_LEN))) &
                  (cnt_r == 2'd1) & dout_ready;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_ENC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ENC: begin
                if (final_s) begin
                    state_next_s = S_IDLE;
                end else if (accept_s & din_last & TAIL_EN) begin
                    state_next_s = S_TAIL;
                end else begin
                    state_next_s = S_ENC;
                end
            end
            S_TAIL: begin
                if (final_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_TAIL;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shift register, puncture phase, tail counter and frame-level flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_r        <= '0;
            phase_r     <= 2'd0;
            mode_r      <= 2'd0;
            tail_cnt_r  <= '0;
            last_seen_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= final_s;
            if (start_acc_s) begin
                sr_r        <= '0;
                phase_r     <= 2'd0;
                mode_r      <= punct_mode;
                tail_cnt_r  <= '0;
                last_seen_r <= 1'b0;
            end else begin
                if (enc_s) begin
                    sr_r    <= {enc_bit_s, sr_r[K-2:1]};
                    phase_r <= phase_next_s;
                end
                if (tail_inj_s) begin
                    tail_cnt_r <= tail_cnt_r + TW'(1);
                end
                if (accept_s & din_last & ~TAIL_EN) begin
                    last_seen_r <= 1'b1;
                end
            end
        end
    end

    // Pending buffer: bit 0 is the oldest; a load always lands on an empty or draining slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r <= 2'b00;
            cnt_r  <= 2'd0;
        end else if (enc_s) begin
            if (keep_a_s & keep_b_s) begin
                pend_r <= {b_s, a_s};
                cnt_r  <= 2'd2;
            end else if (keep_a_s) begin
                pend_r <= {1'b0, a_s};
                cnt_r  <= 2'd1;
            end else begin
                pend_r <= {1'b0, b_s};
                cnt_r  <= 2'd1;
            end
        end else if (consume_s) begin
            pend_r <= {1'b0, pend_r[1]};
            cnt_r  <= cnt_r - 2'd1;
        end
    end

    assign din_ready  = din_ready_s;
    assign dout       = pend_r[0];
    assign dout_valid = (cnt_r != 2'd0);
    assign busy       = (state_r != S_IDLE);
    assign done       = done_r;

endmodule

// File: tb/tb_conv_enc_param.sv
// Scoreboard bench for conv_enc_param: a tailed instance under random traffic and
// back-pressure, plus an untailed instance for the no-flush frame.
module tb_conv_enc_param;

    localparam int           K  = 7;
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;

    typedef bit bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, din, din_valid, din_last, din_ready, dout, dout_valid, dout_ready, busy, done;
    logic [1:0] punct_mode;
    logic       start_t, din_t, din_valid_t, din_last_t, din_ready_t, dout_t, dout_valid_t, dout_ready_t, busy_t, done_t;
    logic [1:0] punct_mode_t;

    conv_enc_param #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .punct_mode(punct_mode),
        .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done));

    conv_enc_param #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b0)) u_dut_nt (
        .clk(clk), .reset(reset), .start(start_t), .punct_mode(punct_mode_t),
        .din(din_t), .din_valid(din_valid_t), .din_last(din_last_t), .din_ready(din_ready_t),
        .dout(dout_t), .dout_valid(dout_valid_t), .dout_ready(dout_ready_t),
        .busy(busy_t), .done(done_t));

    int  errors = 0;
    int  checks = 0;
    bit  exp_q[$];
    bit  exp_t_q[$];
    int  hs_cnt = 0;
    int  done_cnt = 0;
    int  done_t_cnt = 0;
    int  ready_style = 0;
    int  stall_left = 0;
    bit  prev_stall = 1'b0;
    logic prev_dout = 1'b0;
    bit  tput_on = 1'b0;
    bit  tput_seen = 1'b0;
    int  tput_gap = 0;
    int  tput_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: direct convolution over the zero-padded input sequence, then the puncture table.
    function automatic bq_t model(input bq_t x, input int mode, input bit tail_en);
        bq_t y;
        bq_t o;
        logic [K-1:0] g0;
        logic [K-1:0] g1;
        int period;
        g0 = G0;
        g1 = G1;
        y = x;
        if (tail_en) for (int i = 0; i < K - 1; i++) y.push_back(1'b0);
        period = (mode == 1) ? 2 : (mode == 2) ? 3 : 1;
        for (int n = 0; n < y.size(); n++) begin
            bit a = 1'b0;
            bit b = 1'b0;
            int ph = n % period;
            for (int j = 0; j < K; j++) begin
                if (n - j >= 0) begin
                    a ^= g0[K-1-j] & y[n-j];
                    b ^= g1[K-1-j] & y[n-j];
                end
            end
            if ((mode == 1 && ph == 1) || (mode == 2 && ph == 1)) o.push_back(a);
            else if (mode == 2 && ph == 2) o.push_back(b);
            else begin
                o.push_back(a);
                o.push_back(b);
            end
        end
        return o;
    endfunction

    task automatic push_const(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    // Back-pressure generator for the tailed instance.
    always @(posedge clk) begin
        #1;
        if (ready_style == 0) begin
            dout_ready = 1'b1;
        end else if (stall_left > 0) begin
            dout_ready = 1'b0;
            stall_left--;
        end else if ($urandom_range(0, 9) == 0) begin
            dout_ready = 1'b0;
            stall_left = 4;
        end else begin
            dout_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor for the tailed instance: scoreboard pop, stall stability, done/busy and throughput.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("stall_hold_valid", dout_valid, 1);
                check("stall_hold_data", dout, prev_dout);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) check("dout_extra_bit", hs_cnt, 32'hffffffff);
                else check("dout", dout, exp_q.pop_front());
                hs_cnt++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
            end
            if (tput_on) begin
                if (dout_valid) tput_seen = 1'b1;
                if (tput_seen && busy) begin
                    tput_cycles++;
                    if (!dout_valid) tput_gap++;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Monitor for the untailed instance.
    always @(negedge clk) begin
        if (reset) begin
            if (dout_valid_t && dout_ready_t) begin
                if (exp_t_q.size() == 0) check("dout_t_extra_bit", 0, 1);
                else check("dout_t", dout_t, exp_t_q.pop_front());
            end
            if (done_t) begin
                done_t_cnt++;
                check("busy_t_low_at_done", busy_t, 0);
            end
        end
    end

    task automatic send_bits(input bq_t bits, input bit gaps, input bit mid_start);
        for (int i = 0; i < bits.size(); i++) begin
            int to = 0;
            bit acc;
            if (gaps && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                @(posedge clk);
                #2;
            end
            din       = bits[i];
            din_valid = 1'b1;
            din_last  = (i == bits.size() - 1);
            if (mid_start && i == 1) begin
                start      = 1'b1;
                punct_mode = 2'd2;
            end
            forever begin
                @(negedge clk);
                acc = din_ready;
                @(posedge clk);
                #2;
                start = 1'b0;
                if (acc) break;
                to++;
                if (to > 100) begin
                    check("din_accept_timeout", to, 0);
                    break;
                end
            end
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic begin_frame(input logic [1:0] mode);
        @(posedge clk);
        #2;
        start      = 1'b1;
        punct_mode = mode;
        @(posedge clk);
        #2;
        start      = 1'b0;
        punct_mode = 2'($urandom_range(0, 3));
        check("busy_after_start", busy, 1);
    endtask

    task automatic end_frame(input int d0);
        int to = 0;
        while (done_cnt == d0 && to < 500) begin
            @(posedge clk);
            to++;
        end
        repeat (3) @(posedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_frame(input bq_t bits, input logic [1:0] mode, input bit gaps, input bit mid_start);
        int d0 = done_cnt;
        begin_frame(mode);
        send_bits(bits, gaps, mid_start);
        end_frame(d0);
    endtask

    initial begin
        bq_t imp;
        bq_t zeros;
        bq_t bits;
        bq_t m;
        int  d0;
        int  h0;
        int  to;
        reset = 1'b0;
        start = 1'b0; punct_mode = 2'd0; din = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        dout_ready = 1'b1;
        start_t = 1'b0; punct_mode_t = 2'd0; din_t = 1'b0; din_valid_t = 1'b0; din_last_t = 1'b0;
        dout_ready_t = 1'b1;
        imp.push_back(1'b1);
        repeat (3) @(posedge clk);
        #2;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_t_busy", busy_t, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("idle_din_ready", din_ready, 0);

        // Impulse responses in each mode, full-rate sink.
        push_const(32'b11101111000111, 14);
        run_frame(imp, 2'd0, 1'b0, 1'b0);
        push_const(32'b1111110111, 10);
        run_frame(imp, 2'd2, 1'b0, 1'b0);
        push_const(32'b11111100011, 11);
        run_frame(imp, 2'd1, 1'b0, 1'b0);

        // Twenty zeros at rate 1/2: 52 coded bits back to back.
        for (int i = 0; i < 20; i++) zeros.push_back(1'b0);
        m = model(zeros, 0, 1'b1);
        foreach (m[i]) exp_q.push_back(m[i]);
        check("zero_frame_len", m.size(), 52);
        tput_on = 1'b1; tput_seen = 1'b0; tput_gap = 0; tput_cycles = 0;
        h0 = hs_cnt;
        run_frame(zeros, 2'd0, 1'b0, 1'b0);
        tput_on = 1'b0;
        check("tput_gaps", tput_gap, 0);
        check("tput_cycles", tput_cycles, 52);
        check("tput_handshakes", hs_cnt - h0, 52);

        // Impulse under random back-pressure with 5-cycle stalls.
        ready_style = 1;
        push_const(32'b11101111000111, 14);
        run_frame(imp, 2'd0, 1'b0, 1'b0);

        // Random frames and modes against the reference model; one with a start pulse mid-frame.
        for (int f = 0; f < 8; f++) begin
            int mode = $urandom_range(0, 3);
            int len  = $urandom_range(1, 12);
            bits.delete();
            for (int i = 0; i < len; i++) bits.push_back(1'($urandom_range(0, 1)));
            ready_style = $urandom_range(0, 1);
            m = model(bits, mode, 1'b1);
            foreach (m[i]) exp_q.push_back(m[i]);
            run_frame(bits, 2'(mode), 1'b1, (f == 3) && (len > 2));
        end

        // Reset after three coded bits, then a clean impulse frame.
        ready_style = 0;
        d0 = done_cnt;
        push_const(32'b11101111000111, 14);
        h0 = hs_cnt;
        begin_frame(2'd0);
        send_bits(imp, 1'b0, 1'b0);
        to = 0;
        while (hs_cnt < h0 + 3 && to < 100) begin
            @(posedge clk);
            to++;
        end
        check("abort_reach_3_bits", hs_cnt - h0, 3);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("abort_valid_low", dout_valid, 0);
        check("abort_busy_low", busy, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        push_const(32'b11101111000111, 14);
        run_frame(imp, 2'd0, 1'b0, 1'b0);

        // Untailed instance: bits 1,0 (last) with a start pulse mid-frame.
        exp_t_q.push_back(1'b1); exp_t_q.push_back(1'b1);
        exp_t_q.push_back(1'b1); exp_t_q.push_back(1'b0);
        d0 = done_t_cnt;
        @(posedge clk);
        #2;
        start_t = 1'b1;
        punct_mode_t = 2'd0;
        @(posedge clk);
        #2;
        start_t = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int tt = 0;
            bit acc;
            din_t = (i == 0);
            din_valid_t = 1'b1;
            din_last_t = (i == 1);
            start_t = (i == 1);
            punct_mode_t = 2'd2;
            forever begin
                @(negedge clk);
                acc = din_ready_t;
                @(posedge clk);
                #2;
                start_t = 1'b0;
                if (acc || tt > 50) break;
                tt++;
            end
            check("t_accept", acc, 1);
        end
        din_valid_t = 1'b0;
        din_last_t = 1'b0;
        to = 0;
        while (done_t_cnt == d0 && to < 100) begin
            @(posedge clk);
            to++;
        end
        repeat (3) @(posedge clk);
        check("t_done_pulses", done_t_cnt - d0, 1);
        check("t_scoreboard_empty", exp_t_q.size(), 0);
        check("t_busy_idle", busy_t, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_enc_param.md
Name: conv_enc_param

Overview:
- Parametrised rate-1/2 feed-forward convolutional encoder with run-time puncturing (rate 1/2, 2/3, 3/4) and optional zero-tail termination.
- Serial bit input and serial coded-bit output, both with valid/ready handshakes.
- Sits between the scrambler and the interleaver in the TX bit pipeline.
- Successor to the fixed K=3, free-running, unhandshaked encoder.

Parameters:
- K, 7, constraint length (3..9); shift register holds K-1 past bits.
- G0, 7'o171, generator A, K bits, MSB taps the current input bit.
- G1, 7'o133, generator B, K bits, MSB taps the current input bit.
- TAIL_EN, 1, 1 = append K-1 zero tail bits after din_last; 0 = no flush.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame start pulse; honoured only in IDLE.
- punct_mode  in  2  0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = treated as 1/2; sampled on accepted start.
- din  in  1  uncoded data bit.
- din_valid  in  1  din qualifier.
- din_last  in  1  marks the final data bit of the frame; qualified by din_valid.
- din_ready  out  1  encoder accepts din this cycle.
- dout  out  1  coded bit.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  downstream accepts dout.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse after the last coded bit of the frame is consumed.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; shift register, puncture phase, pending buffer and tail counter cleared.
  - Outputs: din_ready=0, dout=0, dout_valid=0, busy=0, done=0.
  - Reset mid-frame discards all in-flight bits; no done pulse.
- FSM: IDLE, ENC, TAIL.
  - IDLE: start=1 → ENC. On entry, clear the shift register and puncture phase, and latch punct_mode.
  - ENC: a bit is accepted when din_valid & din_ready.
    - If din_last is accepted and TAIL_EN=1 → TAIL.
    - If din_last is accepted and TAIL_EN=0 → drain the pending buffer, pulse done, go to IDLE.
  - TAIL: internally inject K-1 zero bits, one per free slot, with the same timing as accepted data. After the last tail bit's coded bits are consumed, pulse done and go to IDLE.
- Encoding of bit b:
  - v = {b, sr[K-2:0]}, with sr[K-2] the most recent prior bit.
  - A = ^(v & G0), B = ^(v & G1).
  - Then sr <= {b, sr[K-2:1]}.
- Puncturing (phase counter advances per encoded bit, data or tail; wraps at the period):
  - Mode 0: period 1; emit A then B.
  - Mode 1: period 2; phase 0 emits A,B; phase 1 emits A.
  - Mode 2: period 3; phase 0 emits A,B; phase 1 emits A; phase 2 emits B.
  - The tail is punctured identically. The phase is not reset between data and tail.
- Pending buffer (holds 0..2 bits):
  - dout_valid = (pending count != 0); dout = oldest pending bit.
  - dout and dout_valid hold stable while dout_ready=0.
  - din_ready = ENC & (count==0 | (count==1 & dout_ready)).
  - A tail bit is injected under the same condition while in TAIL.
  - Simultaneous consume and load in the same cycle is legal; there is no bubble.
  - Full rate-1/2 throughput is 1 input bit per 2 cycles.
- done: asserted in the cycle after the final dout handshake; busy drops in that same cycle.
- start outside IDLE is ignored. din_valid outside ENC is ignored; din_ready=0 there.
- A frame of a single bit with din_last=1 is legal.

Test Plan:
- Defaults, mode 0, start, then single bit 1 with din_last, dout_ready=1 → 14 bits 1,1,1,0,1,1,1,1,0,0,0,1,1,1; then done pulse, busy=0.
- Same input, mode 2 → 10 bits 1,1,1,1,1,1,0,1,1,1; mode 1 → 11 bits 1,1,1,1,1,1,0,0,0,1,1.
- Mode 0, 20 zero bits with TAIL_EN=1 → 52 zeros, dout_valid never drops while dout_ready=1, din_ready duty 50%.
- Mode 0 impulse with dout_ready toggled randomly, including 5-cycle stalls → dout stable during stalls; sequence identical to test 1; no bit lost or duplicated.
- Assert reset=0 after 3 coded bits, release, start a new impulse frame → full 14-bit sequence from test 1; no stale bits; no done for the aborted frame.
- TAIL_EN=0, mode 0, bits 1,0 (last) → 4 bits 1,1,1,0; then done; start pulsed mid-frame has no effect.
